// File: rtl/avg_nearest_stream.sv
// avg_nearest_stream: sliding-window filter returning the window entry nearest
// to floor(window sum / DEPTH). Samples are accepted only while idle; each
// accept that leaves the window full starts a restoring divide followed by a
// sequential nearest-entry scan.
// Ports:
//   clk, reset              clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready/in_data    sample input handshake
//   out_valid/out_ready          result output handshake
//   out_data                     window entry nearest the mean
//   out_avg                      floor(window sum / DEPTH)
//   primed                       window has been filled since reset
module avg_nearest_stream #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned DEPTH   = 12,
  parameter bit          TIE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [WIDTH-1:0] out_avg,
  output logic             primed
);

  localparam int unsigned SUMW = WIDTH + $clog2(DEPTH + 1);
  localparam int unsigned PW   = $clog2(DEPTH);
  localparam int unsigned CW   = $clog2(DEPTH + 1);
  localparam int unsigned DCW  = $clog2(SUMW + 1);
  localparam int unsigned RW   = $clog2(DEPTH) + 1;
  localparam int unsigned TW   = RW + 1;

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_SCAN, S_OUT} state_t;

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  win [DEPTH];
  logic [PW-1:0]     wr_ptr, scan_ptr;
  logic [CW-1:0]     fill, scan_cnt;
  logic [SUMW-1:0]   sum, sum_nxt;
  logic [DCW-1:0]    div_cnt;
  logic [RW-1:0]     rem, rem_nxt;
  logic [SUMW-1:0]   quo, quo_nxt;
  logic [WIDTH-1:0]  avg, best, best_dist;
  logic [WIDTH-1:0]  scan_x, scan_dist;
  logic [TW-1:0]     trial;
  logic              accept, full_after, qbit, take;

  // Accept qualification and running-sum update
  always_comb begin
    accept     = in_valid & in_ready;
    full_after = (fill >= CW'(DEPTH - 1));
    sum_nxt    = sum + SUMW'(in_data) - SUMW'(win[wr_ptr]);
  end

  // One restoring-division step: shift the next dividend bit into the remainder
  always_comb begin
    trial   = {rem, quo[SUMW-1]};
    qbit    = 1'b0;
    rem_nxt = trial[RW-1:0];
    if (trial >= TW'(DEPTH)) begin
      qbit    = 1'b1;
      rem_nxt = RW'(trial - TW'(DEPTH));
    end
    quo_nxt = {quo[SUMW-2:0], qbit};
  end

  // Scan candidate compare; on equal distance prefer the configured side of the mean
  always_comb begin
    scan_x    = win[scan_ptr];
    scan_dist = (avg >= scan_x) ? (avg - scan_x) : (scan_x - avg);
    take      = (scan_cnt == '0) || (scan_dist < best_dist) ||
                ((scan_dist == best_dist) && (scan_x != best) &&
                 (TIE_LOW ? (scan_x < avg) : (scan_x > avg)));
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept && full_after)                state_nxt = S_DIV;
      S_DIV:  if (div_cnt == DCW'(SUMW - 1))           state_nxt = S_SCAN;
      S_SCAN: if (scan_cnt == CW'(DEPTH - 1))          state_nxt = S_OUT;
      S_OUT:  if (out_valid && out_ready)              state_nxt = S_IDLE;
      default:                                         state_nxt = S_IDLE;
    endcase
  end

  // State register; in_ready tracks the upcoming state so it is low in reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      in_ready <= 1'b0;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt == S_IDLE);
    end
  end

  // Window, running sum, fill tracking
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) win[i] <= '0;
      wr_ptr <= '0;
      fill   <= '0;
      sum    <= '0;
      primed <= 1'b0;
    end else if (accept) begin
      win[wr_ptr] <= in_data;
      sum         <= sum_nxt;
      wr_ptr      <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (fill != CW'(DEPTH)) fill <= fill + CW'(1);
      if (full_after) primed <= 1'b1;
    end
  end

  // Divide, scan and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt   <= '0;
      rem       <= '0;
      quo       <= '0;
      avg       <= '0;
      scan_ptr  <= '0;
      scan_cnt  <= '0;
      best      <= '0;
      best_dist <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_avg   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // Dividend is the sum including the sample accepted on this edge
          quo     <= sum_nxt;
          rem     <= '0;
          div_cnt <= '0;
        end
        S_DIV: begin
          rem      <= rem_nxt;
          quo      <= quo_nxt;
          div_cnt  <= div_cnt + DCW'(1);
          avg      <= quo_nxt[WIDTH-1:0];
          scan_ptr <= wr_ptr;
          scan_cnt <= '0;
        end
        S_SCAN: begin
          if (take) begin
            best      <= scan_x;
            best_dist <= scan_dist;
          end
          scan_ptr <= (scan_ptr == PW'(DEPTH - 1)) ? '0 : scan_ptr + PW'(1);
          scan_cnt <= scan_cnt + CW'(1);
        end
        S_OUT: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_data  <= best;
            out_avg   <= avg;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
